// File: rtl/fp_mul_issue_arbiter_pkg.sv
// Shared definitions for the FP multiplier issue arbiter: opcode encoding and defaults.
package fp_mul_issue_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_FMUL = 2'd0,
    OP_ITOF = 2'd1
  } arith_opcode_t;

  localparam int DEFAULT_NUM_STRANDS = 4;
  localparam int DEFAULT_LATENCY     = 4;

endpackage

// File: rtl/fp_mul_issue_arbiter_if.sv
// Strand request, multiplier issue, rollback and result signals of the issue arbiter.
interface fp_mul_issue_arbiter_if #(
  parameter int NUM_STRANDS     = 4,
  parameter int STRAND_ID_WIDTH = $clog2(NUM_STRANDS)
);
  import fp_mul_issue_arbiter_pkg::*;

  logic [NUM_STRANDS-1:0]           strand_req;
  arith_opcode_t [NUM_STRANDS-1:0]  strand_op;
  logic [NUM_STRANDS-1:0][31:0]     strand_operand1;
  logic [NUM_STRANDS-1:0][31:0]     strand_operand2;
  logic [NUM_STRANDS-1:0]           strand_grant;
  logic                             mul_issue_valid;
  arith_opcode_t                    mul_issue_op;
  logic [31:0]                      mul_issue_operand1;
  logic [31:0]                      mul_issue_operand2;
  logic [31:0]                      mul_result;
  logic                             rollback_en;
  logic [STRAND_ID_WIDTH-1:0]       rollback_strand;
  logic                             result_valid;
  logic [STRAND_ID_WIDTH-1:0]       result_strand;
  logic [31:0]                      result_value;
  logic [NUM_STRANDS-1:0]           strand_pending;

  modport master (
    output strand_req, strand_op, strand_operand1, strand_operand2,
           mul_result, rollback_en, rollback_strand,
    input  strand_grant, mul_issue_valid, mul_issue_op, mul_issue_operand1,
           mul_issue_operand2, result_valid, result_strand, result_value, strand_pending
  );

  modport slave (
    input  strand_req, strand_op, strand_operand1, strand_operand2,
           mul_result, rollback_en, rollback_strand,
    output strand_grant, mul_issue_valid, mul_issue_op, mul_issue_operand1,
           mul_issue_operand2, result_valid, result_strand, result_value, strand_pending
  );
endinterface

// File: rtl/fp_mul_issue_arbiter_rr_arbiter.sv
// Round-robin one-hot arbiter; the pointer moves past the winner when the grant is accepted.
module fp_mul_issue_arbiter_rr_arbiter #(
  parameter int NUM_STRANDS     = 4,
  parameter int STRAND_ID_WIDTH = $clog2(NUM_STRANDS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_STRANDS-1:0]     req,
  input  logic                       accept,
  output logic [NUM_STRANDS-1:0]     grant,
  output logic [STRAND_ID_WIDTH-1:0] grant_idx
);
  logic [STRAND_ID_WIDTH-1:0] ptr_reg;
  logic [STRAND_ID_WIDTH-1:0] ptr_next;
  logic [STRAND_ID_WIDTH-1:0] cand_idx;
  logic                       found;
  int                         cand;

  // Scan from the pointer upward, wrapping, and take the first requester.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = 0; off < NUM_STRANDS; off++) begin
      cand = int'(ptr_reg) + off;
      if (cand >= NUM_STRANDS) cand = cand - NUM_STRANDS;
      cand_idx = STRAND_ID_WIDTH'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (accept && found) begin
      if (grant_idx == STRAND_ID_WIDTH'(NUM_STRANDS - 1)) ptr_next = '0;
      else                                                 ptr_next = grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_reg <= '0;
    else       ptr_reg <= ptr_next;
  end
endmodule

// File: rtl/fp_mul_issue_arbiter.sv
// Shares one fixed-latency pipelined FP multiplier among several strands, tags each op with
// its owner so results can be routed back, and drops ops belonging to rolled-back strands.
module fp_mul_issue_arbiter
  import fp_mul_issue_arbiter_pkg::*;
#(
  parameter int NUM_STRANDS     = DEFAULT_NUM_STRANDS,
  parameter int LATENCY         = DEFAULT_LATENCY,
  parameter int STRAND_ID_WIDTH = $clog2(NUM_STRANDS)
) (
  input  logic                  clk,
  input  logic                  reset,
  fp_mul_issue_arbiter_if.slave bus
);
  typedef struct packed {
    logic                       valid;
    logic [STRAND_ID_WIDTH-1:0] strand;
  } tag_t;

  logic [NUM_STRANDS-1:0]     eligible;
  logic [NUM_STRANDS-1:0]     grant;
  logic [NUM_STRANDS-1:0]     kill_mask;
  logic [NUM_STRANDS-1:0]     retire_mask;
  logic [NUM_STRANDS-1:0]     pending_reg;
  logic [NUM_STRANDS-1:0]     pending_next;
  logic [STRAND_ID_WIDTH-1:0] grant_idx;
  logic                       grant_any;
  logic                       result_valid;
  tag_t                       issue_tag_reg;
  tag_t                       tag_reg [LATENCY];
  arith_opcode_t              issue_op_reg;
  logic [31:0]                issue_operand1_reg;
  logic [31:0]                issue_operand2_reg;

  function automatic tag_t apply_kill(input tag_t t, input logic en,
                                      input logic [STRAND_ID_WIDTH-1:0] strand);
    tag_t r;
    r = t;
    if (en && (t.strand == strand)) r.valid = 1'b0;
    return r;
  endfunction

  // A strand being rolled back this cycle must not be granted in the same cycle.
  for (genvar gi = 0; gi < NUM_STRANDS; gi++) begin : g_strand
    assign kill_mask[gi]   = bus.rollback_en && (bus.rollback_strand == STRAND_ID_WIDTH'(gi));
    assign retire_mask[gi] = result_valid && (tag_reg[LATENCY-1].strand == STRAND_ID_WIDTH'(gi));
    assign eligible[gi]    = bus.strand_req[gi] && !pending_reg[gi] && !kill_mask[gi];
  end

  fp_mul_issue_arbiter_rr_arbiter #(
    .NUM_STRANDS     (NUM_STRANDS),
    .STRAND_ID_WIDTH (STRAND_ID_WIDTH)
  ) u_rr_arbiter (
    .clk       (clk),
    .reset     (reset),
    .req       (eligible),
    .accept    (1'b1),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign grant_any = |grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_tag_reg      <= '0;
      issue_op_reg       <= OP_FMUL;
      issue_operand1_reg <= '0;
      issue_operand2_reg <= '0;
    end else begin
      issue_tag_reg.valid  <= grant_any;
      issue_tag_reg.strand <= grant_idx;
      if (grant_any) begin
        issue_op_reg       <= bus.strand_op[grant_idx];
        issue_operand1_reg <= bus.strand_operand1[grant_idx];
        issue_operand2_reg <= bus.strand_operand2[grant_idx];
      end
    end
  end

  // Clearing has priority, so a retiring or rolled-back strand waits one cycle before re-issue.
  assign pending_next = (pending_reg | grant) & ~(kill_mask | retire_mask);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending_reg <= '0;
    else       pending_reg <= pending_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) tag_reg[i] <= '0;
    end else begin
      tag_reg[0] <= apply_kill(issue_tag_reg, bus.rollback_en, bus.rollback_strand);
      for (int i = 1; i < LATENCY; i++)
        tag_reg[i] <= apply_kill(tag_reg[i-1], bus.rollback_en, bus.rollback_strand);
    end
  end

  assign result_valid = tag_reg[LATENCY-1].valid &&
                        !(bus.rollback_en && (bus.rollback_strand == tag_reg[LATENCY-1].strand));

  assign bus.strand_grant       = grant;
  assign bus.mul_issue_valid    = issue_tag_reg.valid;
  assign bus.mul_issue_op       = issue_op_reg;
  assign bus.mul_issue_operand1 = issue_operand1_reg;
  assign bus.mul_issue_operand2 = issue_operand2_reg;
  assign bus.result_valid       = result_valid;
  assign bus.result_strand      = tag_reg[LATENCY-1].strand;
  assign bus.result_value       = result_valid ? bus.mul_result : 32'd0;
  assign bus.strand_pending     = pending_reg;
endmodule

// File: tb/tb_fp_mul_issue_arbiter.sv
// Directed and randomized checks of the issue arbiter against an in-flight-list reference model.
module tb_fp_mul_issue_arbiter;
  import fp_mul_issue_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int L   = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_mul_issue_arbiter_if #(.NUM_STRANDS(N), .STRAND_ID_WIDTH(IDW)) bus ();

  fp_mul_issue_arbiter #(.NUM_STRANDS(N), .LATENCY(L), .STRAND_ID_WIDTH(IDW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Truncating single-precision multiply used as the stand-in multiplier datapath.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
    if (p[47]) return {a[31] ^ b[31], 8'(e + 10'd1), p[46:24]};
    return {a[31] ^ b[31], e[7:0], p[45:23]};
  endfunction

  logic [31:0] pa [L];
  logic [31:0] pb [L];
  always @(posedge clk) begin
    pa[0] <= bus.mul_issue_operand1;
    pb[0] <= bus.mul_issue_operand2;
    for (int k = 1; k < L; k++) begin
      pa[k] <= pa[k-1];
      pb[k] <= pb[k-1];
    end
  end
  assign bus.mul_result = fmul(pa[L-1], pb[L-1]);

  // ---------------- reference model ----------------
  typedef struct {
    int          strand;
    int          due;
    bit          killed;
    logic [31:0] a;
    logic [31:0] b;
  } flight_t;

  flight_t       fl[$];
  int            cyc    = 0;
  int            m_ptr  = 0;
  logic [N-1:0]  m_pend = '0;
  logic          m_iv   = 1'b0;
  arith_opcode_t m_iop  = OP_FMUL;
  logic [31:0]   m_ia   = '0;
  logic [31:0]   m_ib   = '0;
  int            d_grant  = -1;
  int            d_retire = -1;
  logic          d_rb     = 1'b0;
  int            d_rbs    = 0;
  arith_opcode_t d_op     = OP_FMUL;
  logic [31:0]   d_a      = '0;
  logic [31:0]   d_b      = '0;

  always @(negedge clk) begin : compare
    logic [N-1:0] eg;
    logic         ev;
    int           es;
    int           s;
    logic [31:0]  evalue;
    if (reset) begin
      fl.delete();
      m_ptr = 0; m_pend = '0; m_iv = 1'b0; m_iop = OP_FMUL; m_ia = '0; m_ib = '0;
    end
    eg = '0;
    d_grant = -1;
    for (int k = 0; k < N; k++) begin
      s = (m_ptr + k) % N;
      if (d_grant < 0 && bus.strand_req[s] && !m_pend[s] &&
          !(bus.rollback_en && int'(bus.rollback_strand) == s))
        d_grant = s;
    end
    if (d_grant >= 0) begin
      eg[d_grant] = 1'b1;
      d_op = bus.strand_op[d_grant];
      d_a  = bus.strand_operand1[d_grant];
      d_b  = bus.strand_operand2[d_grant];
    end
    d_rb  = bus.rollback_en;
    d_rbs = int'(bus.rollback_strand);
    ev = 1'b0; es = 0; evalue = '0; d_retire = -1;
    foreach (fl[i]) begin
      if (fl[i].due == cyc && !fl[i].killed && !(d_rb && d_rbs == fl[i].strand)) begin
        ev = 1'b1; es = fl[i].strand; evalue = fmul(fl[i].a, fl[i].b); d_retire = es;
      end
    end
    chk("grant", 32'(bus.strand_grant), 32'(eg));
    chk("issue_valid", 32'(bus.mul_issue_valid), 32'(m_iv));
    chk("issue_op", 32'(bus.mul_issue_op), 32'(m_iop));
    chk("issue_operand1", bus.mul_issue_operand1, m_ia);
    chk("issue_operand2", bus.mul_issue_operand2, m_ib);
    chk("result_valid", 32'(bus.result_valid), 32'(ev));
    chk("result_value", bus.result_value, evalue);
    if (ev) chk("result_strand", 32'(bus.result_strand), 32'(es));
    chk("pending", 32'(bus.strand_pending), 32'(m_pend));
  end

  always @(posedge clk) begin : model_step
    flight_t f;
    if (!reset) begin
      if (d_rb) begin
        foreach (fl[i]) if (fl[i].strand == d_rbs) fl[i].killed = 1'b1;
        m_pend[d_rbs] = 1'b0;
      end
      if (d_retire >= 0) m_pend[d_retire] = 1'b0;
      if (d_grant >= 0) begin
        m_pend[d_grant] = 1'b1;
        m_ptr = (d_grant + 1) % N;
        f.strand = d_grant; f.due = cyc + 1 + L; f.killed = 1'b0; f.a = d_a; f.b = d_b;
        fl.push_back(f);
        m_iv = 1'b1; m_iop = d_op; m_ia = d_a; m_ib = d_b;
      end else begin
        m_iv = 1'b0;
      end
      for (int i = fl.size() - 1; i >= 0; i--) if (fl[i].due <= cyc) fl.delete(i);
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) next_cycle();
  endtask

  function automatic logic [31:0] rand_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  initial begin : stim
    int          order[$];
    int          cycles[$];
    int          cnt;
    int          r0;
    int          r3;
    int          fifth_at;
    logic [N-1:0] g;
    logic [N-1:0] req_v;

    reset = 1'b1;
    bus.strand_req = '0;
    bus.rollback_en = 1'b0;
    bus.rollback_strand = '0;
    for (int s = 0; s < N; s++) begin
      bus.strand_op[s] = OP_FMUL;
      bus.strand_operand1[s] = rand_fp();
      bus.strand_operand2[s] = rand_fp();
    end
    @(negedge clk);
    chk("reset_issue_valid", 32'(bus.mul_issue_valid), 32'd0);
    chk("reset_pending", 32'(bus.strand_pending), 32'd0);
    chk("reset_result_valid", 32'(bus.result_valid), 32'd0);
    next_cycle();
    reset = 1'b0;
    next_cycle();

    // Fairness: everyone requests continuously.
    bus.strand_req = '1;
    fifth_at = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int s = 0; s < N; s++) if (bus.strand_grant[s]) begin
        order.push_back(s);
        if (order.size() == 5) fifth_at = c;
      end
      next_cycle();
    end
    bus.strand_req = '0;
    chk("fair_count", 32'(order.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("fair_order%0d", i), 32'(order[i]), 32'(i % 4));
    chk("fair_regrant_cycle", 32'(fifth_at), 32'd6);
    drain(8);

    // Single op on strand 2.
    bus.strand_op[2] = OP_FMUL;
    bus.strand_operand1[2] = 32'h4000_0000;
    bus.strand_operand2[2] = 32'h4040_0000;
    bus.strand_req = 4'b0100;
    @(negedge clk);
    chk("single_grant", 32'(bus.strand_grant), 32'h4);
    next_cycle();
    bus.strand_req = '0;
    @(negedge clk);
    chk("single_issue_valid", 32'(bus.mul_issue_valid), 32'd1);
    chk("single_issue_operand1", bus.mul_issue_operand1, 32'h4000_0000);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k < 4) chk($sformatf("single_early%0d", k), 32'(bus.result_valid), 32'd0);
    end
    chk("single_result_valid", 32'(bus.result_valid), 32'd1);
    chk("single_result_strand", 32'(bus.result_strand), 32'd2);
    chk("single_result_value", bus.result_value, 32'h40C0_0000);
    drain(3);

    // Pending gate: strand 1 keeps requesting.
    bus.strand_req = 4'b0010;
    cnt = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (bus.strand_grant[1]) cycles.push_back(c);
      if (bus.strand_pending[1]) cnt++;
      next_cycle();
    end
    bus.strand_req = '0;
    chk("gate_grants", 32'(cycles.size()), 32'd2);
    chk("gate_first", 32'(cycles[0]), 32'd0);
    chk("gate_second", 32'(cycles[1]), 32'd6);
    chk("gate_pending_len", 32'(cnt), 32'(L + 1));
    drain(8);

    // Rollback of strand 0 with strand 3 in flight behind it.
    bus.strand_req = 4'b0001;
    @(negedge clk);
    chk("rb_grant0", 32'(bus.strand_grant), 32'h1);
    next_cycle();
    bus.strand_req = 4'b1000;
    @(negedge clk);
    chk("rb_grant3", 32'(bus.strand_grant), 32'h8);
    next_cycle();
    bus.strand_req = '0;
    bus.rollback_en = 1'b1;
    bus.rollback_strand = 2'd0;
    next_cycle();
    bus.rollback_en = 1'b0;
    r0 = 0; r3 = 0;
    for (int c = 3; c < 11; c++) begin
      @(negedge clk);
      if (c == 3) chk("rb_pending0", 32'(bus.strand_pending[0]), 32'd0);
      if (bus.result_valid && bus.result_strand == 2'd0) r0++;
      if (bus.result_valid && bus.result_strand == 2'd3) r3++;
      next_cycle();
    end
    chk("rb_results0", 32'(r0), 32'd0);
    chk("rb_results3", 32'(r3), 32'd1);
    drain(2);

    // Rollback and request from the same strand in the same cycle.
    bus.strand_req = 4'b0110;
    bus.rollback_en = 1'b1;
    bus.rollback_strand = 2'd1;
    @(negedge clk);
    chk("simrb_grant", 32'(bus.strand_grant), 32'h4);
    next_cycle();
    bus.rollback_en = 1'b0;
    bus.strand_req = 4'b0010;
    @(negedge clk);
    chk("simrb_next_grant", 32'(bus.strand_grant), 32'h2);
    next_cycle();
    bus.strand_req = '0;
    drain(8);

    // Reset with three ops in flight.
    bus.strand_req = '1;
    drain(3);
    bus.strand_req = '0;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_issue_valid", 32'(bus.mul_issue_valid), 32'd0);
    chk("rst_issue_op", 32'(bus.mul_issue_op), 32'd0);
    chk("rst_issue_operand1", bus.mul_issue_operand1, 32'd0);
    chk("rst_issue_operand2", bus.mul_issue_operand2, 32'd0);
    chk("rst_result_valid", 32'(bus.result_valid), 32'd0);
    chk("rst_result_strand", 32'(bus.result_strand), 32'd0);
    chk("rst_result_value", bus.result_value, 32'd0);
    chk("rst_pending", 32'(bus.strand_pending), 32'd0);
    next_cycle();
    reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.result_valid) cnt++;
      next_cycle();
    end
    chk("rst_no_results", 32'(cnt), 32'd0);
    bus.strand_req = '1;
    @(negedge clk);
    chk("rst_first_grant", 32'(bus.strand_grant), 32'h1);
    next_cycle();
    bus.strand_req = '0;
    drain(8);

    // Randomized traffic with occasional rollbacks.
    req_v = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      g = bus.strand_grant;
      next_cycle();
      req_v &= ~g;
      for (int s = 0; s < N; s++) begin
        if (!req_v[s] && $urandom_range(0, 2) == 0) begin
          req_v[s] = 1'b1;
          bus.strand_op[s] = arith_opcode_t'($urandom_range(0, 1));
          bus.strand_operand1[s] = rand_fp();
          bus.strand_operand2[s] = rand_fp();
        end
      end
      bus.strand_req = req_v;
      bus.rollback_en = ($urandom_range(0, 7) == 0);
      bus.rollback_strand = 2'($urandom_range(0, N - 1));
    end
    @(negedge clk);
    next_cycle();
    bus.strand_req = '0;
    bus.rollback_en = 1'b0;
    drain(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
